// File: rtl/seq_pkg.sv
// Shared state encoding and wait-timeout default for the multicycle sequencer.
// No logic; imported by the sequencer, its wait timer and the bus interface users.
package seq_pkg;

    localparam int TIMEOUT_DEFAULT = 255;
    localparam int WAIT_W          = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_ERROR  = 3'd7
    } state_e;

endpackage

// File: rtl/multicycle_seq_if.sv
// Decoder flags, memory handshakes and control strobes between the sequencer and the datapath.
// Suffixes are from the sequencer's point of view: _i driven by the datapath side, _o by the sequencer.
interface multicycle_seq_if;

    logic        run_i;
    logic        jmp_i;
    logic        jal_i;
    logic        jr_i;
    logic        branch_i;
    logic        nbranch_i;
    logic        mem_to_reg_i;
    logic        mem_write_i;
    logic        reg_write_i;
    logic        imem_ready_i;
    logic        dmem_ready_i;

    logic        imem_req_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic        ir_we_o;
    logic        reg_we_o;
    logic        pc_we_o;
    logic [2:0]  stage_o;
    logic        err_o;
    logic [31:0] retired_o;

    modport master (
        output run_i, jmp_i, jal_i, jr_i, branch_i, nbranch_i,
               mem_to_reg_i, mem_write_i, reg_write_i, imem_ready_i, dmem_ready_i,
        input  imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, reg_we_o, pc_we_o,
               stage_o, err_o, retired_o
    );

    modport slave (
        input  run_i, jmp_i, jal_i, jr_i, branch_i, nbranch_i,
               mem_to_reg_i, mem_write_i, reg_write_i, imem_ready_i, dmem_ready_i,
        output imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, reg_we_o, pc_we_o,
               stage_o, err_o, retired_o
    );

endinterface

// File: rtl/wait_timer.sv
// Counts consecutive not-ready cycles of a memory wait; expired flags the TIMEOUT-th one combinationally.
// A ready cycle never ticks, so a ready arriving on that last cycle always beats the timeout.
module wait_timer
    import seq_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic tick_i,
    output logic expired_o
);

    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT - 1);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (tick_i) begin
            cnt_d = cnt_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = tick_i && (cnt_q == LAST_WAIT);

endmodule

// File: rtl/multicycle_seq.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control strobes, retire count, wait timeout.
// Strobes are combinational on state and inputs; memory waits stall in place until ready or timeout.
module multicycle_seq
    import seq_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    multicycle_seq_if.slave bus
);

    state_e      state_q;
    state_e      state_d;
    state_e      done_next;
    logic [31:0] retired_q;
    logic [31:0] retired_d;

    logic imem_req, dmem_req, dmem_we, ir_we, reg_we, pc_we;
    logic wait_clear, wait_tick, wait_expired;
    logic is_jump;

    assign done_next = bus.run_i ? ST_FETCH : ST_IDLE;
    assign is_jump   = bus.jmp_i | bus.jr_i | bus.branch_i | bus.nbranch_i;

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        ir_we    = 1'b0;
        reg_we   = 1'b0;
        pc_we    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.run_i) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ready_i) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (wait_expired) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if (bus.jal_i) begin
                    state_d = ST_WB;
                end else if (is_jump) begin
                    pc_we   = 1'b1;
                    state_d = done_next;
                end else if (bus.mem_to_reg_i || bus.mem_write_i) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = bus.mem_write_i;
                if (bus.dmem_ready_i) begin
                    // A store retires here; a load still needs its writeback cycle.
                    if (bus.mem_write_i) begin
                        pc_we   = 1'b1;
                        state_d = done_next;
                    end else if (bus.mem_to_reg_i) begin
                        state_d = ST_WB;
                    end
                end else if (wait_expired) begin
                    state_d = ST_ERROR;
                end
            end
            ST_WB: begin
                reg_we  = bus.reg_write_i;
                pc_we   = 1'b1;
                state_d = done_next;
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign wait_tick  = ((state_q == ST_FETCH) && !bus.imem_ready_i) ||
                        ((state_q == ST_MEM)   && !bus.dmem_ready_i);
    assign wait_clear = (state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM));

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (wait_clear),
        .tick_i    (wait_tick),
        .expired_o (wait_expired)
    );

    assign retired_d = pc_we ? retired_q + 32'd1 : retired_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign bus.imem_req_o = imem_req;
    assign bus.dmem_req_o = dmem_req;
    assign bus.dmem_we_o  = dmem_we;
    assign bus.ir_we_o    = ir_we;
    assign bus.reg_we_o   = reg_we;
    assign bus.pc_we_o    = pc_we;
    assign bus.stage_o    = state_q;
    assign bus.err_o      = (state_q == ST_ERROR);
    assign bus.retired_o  = retired_q;

endmodule

// File: tb/tb_multicycle_seq.sv
// Randomised instruction stream against a latency/strobe-count model; a monitor scores each retirement.
// Directed legs cover reset, retire-count wrap, reset during MEM and both fetch and data timeouts.
module tb_multicycle_seq;

    localparam int TO = 4;
    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                           S_MEM = 3'd4, S_WB = 3'd5, S_ERROR = 3'd7;

    typedef struct packed { bit jmp, jal, jr, br, nbr, mtr, mw, rw; } flags_t;
    typedef struct {
        int          cycles;
        logic [2:0]  final_stage;
        int          reg_we;
        int          dmem_req;
        int          dmem_we;
        int          imem_req;
        logic [31:0] retired;
        logic [2:0]  next_stage;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    multicycle_seq_if bus();

    multicycle_seq #(.TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial forever #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    exp_t        sb_q[$];
    logic [31:0] exp_retired;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected behaviour from the instruction's path: fetch wait, decode, exec, optional mem wait, optional writeback.
    function automatic exp_t model(input flags_t f, input int iw, input int dw, input bit run_end,
                                   input logic [31:0] ret);
        exp_t e;
        e.imem_req   = iw + 1;
        e.cycles     = iw + 3;
        e.reg_we     = 0;
        e.dmem_req   = 0;
        e.dmem_we    = 0;
        e.retired    = ret;
        e.next_stage = run_end ? S_FETCH : S_IDLE;
        if (f.jal) begin
            e.cycles++; e.final_stage = S_WB; e.reg_we = f.rw ? 1 : 0;
        end else if (f.jmp || f.jr || f.br || f.nbr) begin
            e.final_stage = S_EXEC;
        end else if (f.mtr || f.mw) begin
            e.cycles  += dw + 1;
            e.dmem_req = dw + 1;
            e.dmem_we  = f.mw ? dw + 1 : 0;
            if (f.mw) e.final_stage = S_MEM;
            else begin e.cycles++; e.final_stage = S_WB; e.reg_we = f.rw ? 1 : 0; end
        end else begin
            e.cycles++; e.final_stage = S_WB; e.reg_we = f.rw ? 1 : 0;
        end
        return e;
    endfunction

    function automatic flags_t rand_flags(input int kind);
        flags_t f = '0;
        f.rw = rb();
        case (kind)
            1: begin f.mtr = 1'b1; f.rw = 1'b1; end
            2: f.mw = 1'b1;
            3: begin f.jal = 1'b1; f.jmp = rb(); f.mtr = rb(); end
            4: begin
                case ($urandom_range(0, 3))
                    0: f.jmp = 1'b1;
                    1: f.jr  = 1'b1;
                    2: f.br  = 1'b1;
                    default: f.nbr = 1'b1;
                endcase
                f.mtr = rb(); f.mw = rb();
            end
            default: ;
        endcase
        return f;
    endfunction

    task automatic drive_flags(input flags_t f);
        bus.jmp_i = f.jmp; bus.jal_i = f.jal; bus.jr_i = f.jr; bus.branch_i = f.br;
        bus.nbranch_i = f.nbr; bus.mem_to_reg_i = f.mtr; bus.mem_write_i = f.mw; bus.reg_write_i = f.rw;
    endtask

    task automatic do_instr(input flags_t f, input int iw, input int dw, input bit drop_run);
        int fc = 0;
        int mc = 0;
        bit done = 1'b0;
        logic [2:0] st;
        sb_q.push_back(model(f, iw, dw, !drop_run, exp_retired));
        exp_retired = exp_retired + 32'd1;
        drive_flags(f);
        bus.run_i = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            st = bus.stage_o;
            if (st == S_FETCH) begin bus.imem_ready_i = (fc >= iw); fc++; end
            else bus.imem_ready_i = rb();
            if (st == S_MEM) begin bus.dmem_ready_i = (mc >= dw); mc++; end
            else bus.dmem_ready_i = rb();
            if (drop_run && st == S_DECODE) bus.run_i = 1'b0;
            #1;
            done = bus.pc_we_o;
            @(negedge clk);
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL instr_complete no pc_we within 40 cycles (required one)");
        end
    endtask

    task automatic do_reset();
        bus.run_i = 1'b0;
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        exp_retired = '0;
    endtask

    // Monitor: accumulates strobe counts per instruction and scores it on its pc_we cycle.
    int         mon_cyc, n_imem, n_ir, n_dreq, n_dwe, n_reg;
    bit         mon_in = 1'b0, chk_next = 1'b0;
    logic [2:0] next_exp;
    exp_t       mon_e;
    initial forever begin
        @(negedge clk);
        #2;
        if (!mon_en) begin
            mon_in = 1'b0; chk_next = 1'b0;
        end else begin
            if (chk_next) begin chk("next_stage", 32'(bus.stage_o), 32'(next_exp)); chk_next = 1'b0; end
            if (!mon_in && bus.stage_o == S_FETCH) begin
                mon_in = 1'b1; mon_cyc = 0; n_imem = 0; n_ir = 0; n_dreq = 0; n_dwe = 0; n_reg = 0;
            end
            if (mon_in) begin
                mon_cyc++;
                if (bus.imem_req_o) n_imem++;
                if (bus.ir_we_o)    n_ir++;
                if (bus.dmem_req_o) n_dreq++;
                if (bus.dmem_we_o)  n_dwe++;
                if (bus.reg_we_o)   n_reg++;
                if (bus.pc_we_o) begin
                    if (sb_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL sb_underflow pc_we with no instruction outstanding");
                    end else begin
                        mon_e = sb_q.pop_front();
                        chk("cycles",      mon_cyc, mon_e.cycles);
                        chk("final_stage", 32'(bus.stage_o), 32'(mon_e.final_stage));
                        chk("reg_we_cnt",  n_reg,  mon_e.reg_we);
                        chk("dmem_req_cnt", n_dreq, mon_e.dmem_req);
                        chk("dmem_we_cnt", n_dwe,  mon_e.dmem_we);
                        chk("imem_req_cnt", n_imem, mon_e.imem_req);
                        chk("ir_we_cnt",   n_ir,   1);
                        chk("retired",     bus.retired_o, mon_e.retired);
                        next_exp = mon_e.next_stage;
                        chk_next = 1'b1;
                    end
                    mon_in = 1'b0;
                end
            end else if (bus.pc_we_o) begin
                checks++; failures++;
                $display("FAIL stray_pc_we pc_we=1 outside an instruction");
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        flags_t f;
        int nf, nw;
        bit hit;
        rst_n = 1'b0;
        bus.run_i = 1'b0; bus.imem_ready_i = 1'b0; bus.dmem_ready_i = 1'b0;
        drive_flags('0);
        exp_retired = '0;
        @(negedge clk);
        chk("rst_stage",   32'(bus.stage_o), 32'(S_IDLE));
        chk("rst_strobes", 32'({bus.imem_req_o, bus.dmem_req_o, bus.dmem_we_o, bus.ir_we_o,
                                bus.reg_we_o, bus.pc_we_o}), 0);
        chk("rst_retired", bus.retired_o, 0);
        chk("rst_err",     32'(bus.err_o), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("idle_without_run", 32'(bus.stage_o), 32'(S_IDLE));
        end

        mon_en = 1'b1;
        f = '0; f.rw = 1'b1;                do_instr(f, 0, 0, 1'b0);   // R-type add
        f = '0; f.mtr = 1'b1; f.rw = 1'b1;  do_instr(f, 1, 3, 1'b0);   // lw, data ready late
        f = '0; f.mw = 1'b1; f.rw = 1'b1;   do_instr(f, 0, 2, 1'b0);   // sw
        f = '0; f.jal = 1'b1; f.rw = 1'b1;  do_instr(f, 0, 0, 1'b0);
        f = '0; f.br = 1'b1; f.rw = 1'b1;   do_instr(f, 0, 0, 1'b0);   // beq
        f = '0; f.rw = 1'b1;                do_instr(f, TO - 1, 0, 1'b0); // ready on the last allowed cycle
        f = '0; f.mw = 1'b1;                do_instr(f, 0, 0, 1'b1);   // run dropped mid-instruction
        for (int i = 0; i < 40; i++) begin
            do_instr(rand_flags($urandom_range(0, 4)), $urandom_range(0, TO - 1),
                     $urandom_range(0, TO - 1), $urandom_range(0, 3) == 0);
        end
        #3;
        mon_en = 1'b0;
        chk("sb_empty", sb_q.size(), 0);

        // Reset while a load is waiting in MEM.
        f = '0; f.mtr = 1'b1; f.rw = 1'b1; drive_flags(f);
        bus.run_i = 1'b1; bus.imem_ready_i = 1'b1; bus.dmem_ready_i = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            hit = (bus.stage_o == S_MEM);
        end
        #1;
        chk("mem_reached_dmem_req", 32'(bus.dmem_req_o), 1);
        chk("pre_reset_retired", bus.retired_o, exp_retired);
        rst_n = 1'b0;
        #1;
        chk("mem_rst_stage",    32'(bus.stage_o), 32'(S_IDLE));
        chk("mem_rst_dmem_req", 32'(bus.dmem_req_o), 0);
        chk("mem_rst_retired",  bus.retired_o, 0);
        chk("mem_rst_err",      32'(bus.err_o), 0);
        @(negedge clk);
        rst_n = 1'b1; bus.run_i = 1'b0; exp_retired = '0;

        // Retire-count wrap from all-ones.
        force dut.retired_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.retired_q;
        #1;
        chk("preload_retired", bus.retired_o, 32'hFFFF_FFFF);
        exp_retired = 32'hFFFF_FFFF;
        mon_en = 1'b1;
        f = '0; f.rw = 1'b1; do_instr(f, 0, 0, 1'b0);
        #1;
        chk("retired_wrap", bus.retired_o, 0);
        f = '0; f.jr = 1'b1; do_instr(f, 1, 0, 1'b1);
        #3;
        mon_en = 1'b0;

        // Fetch timeout, then ERROR holds regardless of inputs until reset.
        do_reset();
        drive_flags('0);
        bus.run_i = 1'b1; bus.imem_ready_i = 1'b0;
        nf = 0; hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            #1;
            if (bus.stage_o == S_FETCH) nf++;
            else hit = (bus.stage_o == S_ERROR);
        end
        chk("fetch_wait_cycles", nf, TO);
        chk("fetch_to_stage",    32'(bus.stage_o), 32'(S_ERROR));
        chk("fetch_to_err",      32'(bus.err_o), 1);
        for (int c = 0; c < 3; c++) begin
            bus.run_i = rb(); bus.imem_ready_i = 1'b1; bus.dmem_ready_i = 1'b1;
            f = '0; f.jal = 1'b1; drive_flags(f);
            @(negedge clk);
            #1;
            chk("error_hold_stage", 32'(bus.stage_o), 32'(S_ERROR));
            chk("error_strobes", 32'({bus.imem_req_o, bus.dmem_req_o, bus.dmem_we_o, bus.ir_we_o,
                                      bus.reg_we_o, bus.pc_we_o}), 0);
        end
        rst_n = 1'b0;
        #1;
        chk("error_rst_stage", 32'(bus.stage_o), 32'(S_IDLE));
        chk("error_rst_err",   32'(bus.err_o), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Data-memory timeout on a load.
        f = '0; f.mtr = 1'b1; f.rw = 1'b1; drive_flags(f);
        bus.run_i = 1'b1; bus.imem_ready_i = 1'b1; bus.dmem_ready_i = 1'b0;
        nf = 0; nw = 0; hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            #1;
            if (bus.stage_o == S_MEM) begin
                nf++;
                if (bus.dmem_we_o) nw++;
            end else begin
                hit = (bus.stage_o == S_ERROR);
            end
        end
        chk("mem_wait_cycles", nf, TO);
        chk("mem_load_we",     nw, 0);
        chk("mem_to_stage",    32'(bus.stage_o), 32'(S_ERROR));
        chk("mem_to_err",      32'(bus.err_o), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
